// File: rtl/at_hazard_tracker_pkg.sv
// Shared AT-method definitions: instruction classes, forward-select codes and Tuse/Tnew lookups.
package at_pkg;

  localparam logic [3:0] IT_NOP    = 4'd0;
  localparam logic [3:0] IT_CAL_R  = 4'd1;
  localparam logic [3:0] IT_CAL_I  = 4'd2;
  localparam logic [3:0] IT_LOAD   = 4'd3;
  localparam logic [3:0] IT_STORE  = 4'd4;
  localparam logic [3:0] IT_BRANCH = 4'd5;
  localparam logic [3:0] IT_JR     = 4'd6;
  localparam logic [3:0] IT_JAL    = 4'd7;
  localparam logic [3:0] IT_JALR   = 4'd8;

  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_E    = 2'd1;
  localparam logic [1:0] FWD_M    = 2'd2;
  localparam logic [1:0] FWD_W    = 2'd3;

  // Larger than any Tnew, so a "no use" source can never trip the stall compare.
  localparam logic [1:0] TUSE_NONE = 2'd3;

  function automatic logic [1:0] tuse_rs(input logic [3:0] it);
    case (it)
      IT_BRANCH, IT_JR, IT_JALR:               tuse_rs = 2'd0;
      IT_CAL_R, IT_CAL_I, IT_LOAD, IT_STORE:   tuse_rs = 2'd1;
      default:                                 tuse_rs = TUSE_NONE;
    endcase
  endfunction

  function automatic logic [1:0] tuse_rt(input logic [3:0] it);
    case (it)
      IT_BRANCH: tuse_rt = 2'd0;
      IT_CAL_R:  tuse_rt = 2'd1;
      IT_STORE:  tuse_rt = 2'd2;
      default:   tuse_rt = TUSE_NONE;
    endcase
  endfunction

  function automatic logic [1:0] tnew_e(input logic [3:0] it);
    case (it)
      IT_LOAD:            tnew_e = 2'd2;
      IT_CAL_R, IT_CAL_I: tnew_e = 2'd1;
      default:            tnew_e = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/at_hazard_tracker_if.sv
// D-stage AT tuple in, stall and forward selects out.
interface at_hazard_tracker_if #(
  parameter int REG_W = 5,
  parameter int IT_W  = 4
);
  logic [REG_W-1:0] d_rs;
  logic [REG_W-1:0] d_rt;
  logic [REG_W-1:0] d_wr;
  logic [IT_W-1:0]  d_instype;
  logic             stall;
  logic [1:0]       fwd_d_rs;
  logic [1:0]       fwd_d_rt;
  logic [1:0]       fwd_e_rs;
  logic [1:0]       fwd_e_rt;
  logic [1:0]       fwd_m_rt;

  modport master (
    output d_rs, d_rt, d_wr, d_instype,
    input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt
  );

  modport slave (
    input  d_rs, d_rt, d_wr, d_instype,
    output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt
  );
endinterface

// File: rtl/at_hazard_tracker_fwd_sel.sv
// One forward-select point: nearest enabled candidate (E=0, M=1, W=2) whose wr matches src wins.
module at_fwd_sel
  import at_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0]      src,
  input  logic [2:0][REG_W-1:0] cand_wr,
  input  logic [2:0][1:0]       cand_tnew,
  input  logic [2:0]            cand_en,
  output logic [1:0]            sel
);

  logic hit;

  // A matching stage that is not ready yet still shadows farther stages.
  always_comb begin
    sel = FWD_NONE;
    hit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!hit && cand_en[i] && (src != '0) && (cand_wr[i] == src)) begin
        hit = 1'b1;
        sel = (cand_tnew[i] == 2'd0) ? 2'(i + 1) : FWD_NONE;
      end
    end
  end

endmodule

// File: rtl/at_hazard_tracker.sv
// AT hazard tracker: E/M/W shadow records, D-stage stall and five forward selects.
// Define AT_HAZ_WB_FWD_EN to let the D-stage selects return W (no register-file write-through).
module at_hazard_tracker
  import at_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int IT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  at_hazard_tracker_if.slave at
);

`ifdef AT_HAZ_WB_FWD_EN
  localparam logic [2:0] D_MASK = 3'b111;
`else
  localparam logic [2:0] D_MASK = 3'b011;
`endif
  localparam logic [2:0] E_MASK = 3'b110;
  localparam logic [2:0] M_MASK = 3'b100;

  logic [REG_W-1:0] e_rs, e_rt, e_wr, m_rt, m_wr, w_wr;
  logic [1:0]       e_tnew, m_tnew;
  logic [3:0]       d_cls;
  logic [1:0]       rs_tuse, rt_tuse;
  logic             stall;

  assign d_cls   = 4'(at.d_instype);
  assign rs_tuse = tuse_rs(d_cls);
  assign rt_tuse = tuse_rt(d_cls);

  function automatic logic hz(input logic [REG_W-1:0] s, input logic [1:0] tuse,
                              input logic [REG_W-1:0] ewr, input logic [1:0] etn,
                              input logic [REG_W-1:0] mwr, input logic [1:0] mtn);
    hz = (s != '0) && (tuse != TUSE_NONE) &&
         (((ewr == s) && (etn > tuse)) || ((mwr == s) && (mtn > tuse)));
  endfunction

  assign stall = hz(at.d_rs, rs_tuse, e_wr, e_tnew, m_wr, m_tnew) |
                 hz(at.d_rt, rt_tuse, e_wr, e_tnew, m_wr, m_tnew);
  assign at.stall = stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_rs <= '0; e_rt <= '0; e_wr <= '0; e_tnew <= '0;
      m_rt <= '0; m_wr <= '0; m_tnew <= '0;
      w_wr <= '0;
    end else begin
      w_wr   <= m_wr;
      m_rt   <= e_rt;
      m_wr   <= e_wr;
      m_tnew <= (e_tnew != 2'd0) ? e_tnew - 2'd1 : 2'd0;
      if (stall) begin
        e_rs <= '0; e_rt <= '0; e_wr <= '0; e_tnew <= '0;
      end else begin
        e_rs   <= at.d_rs;
        e_rt   <= at.d_rt;
        e_wr   <= at.d_wr;
        e_tnew <= tnew_e(d_cls);
      end
    end
  end

  // Candidate order E, M, W; W's result is always ready.
  logic [2:0][REG_W-1:0] cand_wr;
  logic [2:0][1:0]       cand_tnew;
  logic [4:0][REG_W-1:0] src;
  logic [4:0][2:0]       en;
  logic [4:0][1:0]       sel;

  assign cand_wr   = {w_wr, m_wr, e_wr};
  assign cand_tnew = {2'd0, m_tnew, e_tnew};
  assign src       = {m_rt, e_rt, e_rs, at.d_rt, at.d_rs};
  assign en        = {M_MASK, E_MASK, E_MASK, D_MASK, D_MASK};

  generate
    for (genvar g = 0; g < 5; g++) begin : g_sel
      at_fwd_sel #(.REG_W(REG_W)) u_sel (
        .src       (src[g]),
        .cand_wr   (cand_wr),
        .cand_tnew (cand_tnew),
        .cand_en   (en[g]),
        .sel       (sel[g])
      );
    end
  endgenerate

  assign at.fwd_d_rs = sel[0];
  assign at.fwd_d_rt = sel[1];
  assign at.fwd_e_rs = sel[2];
  assign at.fwd_e_rt = sel[3];
  assign at.fwd_m_rt = sel[4];

endmodule

// File: tb/tb_at_hazard_tracker.sv
// Directed bench for at_hazard_tracker: hand-computed stall/forward expectations per step.
module tb_at_hazard_tracker;
  import at_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   ncmp = 0;
  int   nerr = 0;

`ifdef AT_HAZ_WB_FWD_EN
  localparam logic [1:0] D_W_EXP = 2'd3;
`else
  localparam logic [1:0] D_W_EXP = 2'd0;
`endif

  always #5 clk = ~clk;

  at_hazard_tracker_if #(.REG_W(5), .IT_W(4)) at_bus ();

  at_hazard_tracker #(.REG_W(5), .IT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .at    (at_bus)
  );

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"},    {1'b0, at_bus.stall}, 2'd0);
    chk({tag, "_fwd_d_rs"}, at_bus.fwd_d_rs, 2'd0);
    chk({tag, "_fwd_d_rt"}, at_bus.fwd_d_rt, 2'd0);
    chk({tag, "_fwd_e_rs"}, at_bus.fwd_e_rs, 2'd0);
    chk({tag, "_fwd_e_rt"}, at_bus.fwd_e_rt, 2'd0);
    chk({tag, "_fwd_m_rt"}, at_bus.fwd_m_rt, 2'd0);
  endtask

  task automatic drv(input logic [3:0] it, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] wr);
    at_bus.d_instype = it;
    at_bus.d_rs      = rs;
    at_bus.d_rt      = rt;
    at_bus.d_wr      = wr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    drv(IT_NOP, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drv(IT_NOP, 0, 0, 0);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // lw $1 then addu $2,$1,$3: one-cycle stall, then W forward into E
    drv(IT_LOAD, 0, 0, 1);
    tick();
    drv(IT_CAL_R, 1, 3, 2);
    chk("ld_alu_c0_stall", {1'b0, at_bus.stall}, 2'd1);
    tick();
    chk("ld_alu_c1_stall", {1'b0, at_bus.stall}, 2'd0);
    chk("ld_alu_c1_fwd_d_rs", at_bus.fwd_d_rs, 2'd0);
    tick();
    drv(IT_NOP, 0, 0, 0);
    chk("ld_alu_c2_fwd_e_rs", at_bus.fwd_e_rs, 2'd3);
    chk("ld_alu_c2_fwd_e_rt", at_bus.fwd_e_rt, 2'd0);

    // addu $4 in E, beq $4,$0 in D
    rst_pulse();
    drv(IT_CAL_R, 5, 6, 4);
    tick();
    drv(IT_BRANCH, 4, 0, 0);
    chk("alu_br_stall", {1'b0, at_bus.stall}, 2'd1);
    chk("alu_br_fwd0", at_bus.fwd_d_rs, 2'd0);
    tick();
    chk("alu_br_next_stall", {1'b0, at_bus.stall}, 2'd0);
    chk("alu_br_next_fwd", at_bus.fwd_d_rs, 2'd2);

    // jal then jr $31: E, M, then W position
    rst_pulse();
    drv(IT_JAL, 0, 0, 31);
    tick();
    drv(IT_JR, 31, 0, 0);
    chk("jal_e_stall", {1'b0, at_bus.stall}, 2'd0);
    chk("jal_e_fwd", at_bus.fwd_d_rs, 2'd1);
    drv(IT_NOP, 0, 0, 0);
    tick();
    drv(IT_JR, 31, 0, 0);
    chk("jal_m_fwd", at_bus.fwd_d_rs, 2'd2);
    tick();
    chk("jal_w_fwd", at_bus.fwd_d_rs, D_W_EXP);
    chk("jal_w_stall", {1'b0, at_bus.stall}, 2'd0);

    // lw $5 in E, sw $5 in D: no stall, forward at M from W
    rst_pulse();
    drv(IT_LOAD, 0, 0, 5);
    tick();
    drv(IT_STORE, 0, 5, 0);
    chk("ld_st_stall", {1'b0, at_bus.stall}, 2'd0);
    tick();
    drv(IT_NOP, 0, 0, 0);
    chk("ld_st_fwd_e_rt", at_bus.fwd_e_rt, 2'd0);
    tick();
    chk("ld_st_fwd_m_rt", at_bus.fwd_m_rt, 2'd3);

    // $0 never hazards
    rst_pulse();
    drv(IT_CAL_R, 1, 2, 0);
    tick();
    drv(IT_CAL_R, 0, 0, 3);
    chk_all_zero("r0_d");
    tick();
    chk_all_zero("r0_e");

    // E and M both write $4: E (not ready) wins, stall covers
    rst_pulse();
    drv(IT_CAL_R, 0, 0, 4);
    tick();
    tick();
    drv(IT_BRANCH, 4, 0, 0);
    chk("e_wins_stall", {1'b0, at_bus.stall}, 2'd1);
    chk("e_wins_fwd", at_bus.fwd_d_rs, 2'd0);

    // lw $7 feeding beq: two stall cycles
    rst_pulse();
    drv(IT_LOAD, 0, 0, 7);
    tick();
    drv(IT_BRANCH, 7, 0, 0);
    chk("ld_br_c0_stall", {1'b0, at_bus.stall}, 2'd1);
    tick();
    chk("ld_br_c1_stall", {1'b0, at_bus.stall}, 2'd1);
    chk("ld_br_c1_fwd", at_bus.fwd_d_rs, 2'd0);
    tick();
    chk("ld_br_c2_stall", {1'b0, at_bus.stall}, 2'd0);
    chk("ld_br_c2_fwd", at_bus.fwd_d_rs, D_W_EXP);

    // Reset asserted mid-stall, then D tuple loads into E
    rst_pulse();
    drv(IT_LOAD, 0, 0, 1);
    tick();
    drv(IT_CAL_R, 1, 3, 2);
    chk("mid_pre_stall", {1'b0, at_bus.stall}, 2'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    rst_n = 1'b1;
    #1;
    chk("mid_release_stall", {1'b0, at_bus.stall}, 2'd0);
    tick();
    drv(IT_BRANCH, 2, 0, 0);
    chk("post_rst_e_load_stall", {1'b0, at_bus.stall}, 2'd1);
    chk("post_rst_e_load_fwd", at_bus.fwd_d_rs, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/at_hazard_tracker.md
# at_hazard_tracker

Pipeline hazard unit on the consumer side of the D-stage AT decode (`rs`/`rt`/`wr`/`instype` tuple). It keeps a shadow pipeline of AT records for the E, M and W stages and derives Tnew countdowns from them. From these it produces the D-stage stall and the forwarding-mux selects for every operand consumer point in the five-stage MIPS core.

## Interface
- `REG_W`, default 5: register-address width.
- `IT_W`, default 4: instruction-class width.
- `clk` in 1: pipeline clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `d_rs` in REG_W: D-stage source register; 0 when the instruction does not read rs.
- `d_rt` in REG_W: D-stage rt source; 0 when not read.
- `d_wr` in REG_W: D-stage destination; 0 when there is no write.
- `d_instype` in IT_W: D-stage instruction class.
- `stall` out 1: hold PC and the D register, and inject a bubble into E.
- `fwd_d_rs`, `fwd_d_rt` out 2: D-stage comparator/jr operand selects.
- `fwd_e_rs`, `fwd_e_rt` out 2: ALU input selects.
- `fwd_m_rt` out 2: store-data select.
- Select encoding: 0 = no forward (register file / pipeline value), 1 = E, 2 = M, 3 = W.

## Operation
- Classes: NOP=0, CAL_R=1, CAL_I=2, LOAD=3, STORE=4, BRANCH=5, JR=6, JAL=7, JALR=8. Codes 9–15 are treated as NOP.
- Tuse(rs):
  - BRANCH, JR, JALR: 0.
  - CAL_R, CAL_I, LOAD, STORE: 1.
  - Other classes: no use.
- Tuse(rt):
  - BRANCH: 0.
  - CAL_R: 1.
  - STORE: 2.
  - Other classes: no use.
- Tnew on entry to E:
  - LOAD: 2.
  - CAL_R, CAL_I: 1.
  - JAL, JALR, NOP: 0.
- Records:
  - E holds {rs, rt, wr, tnew}.
  - M holds {rt, wr, tnew}.
  - W holds {wr}.
- Each clock:
  - W ← M.wr.
  - M ← E, with tnew decremented and saturating at 0.
  - E ← D tuple, or an all-zero bubble when `stall` is 1.
- Stall: asserted when, for any D source s≠0 with a defined Tuse, either E or M has wr==s and tnew > Tuse(s). W never stalls.
- Forward select, per consumer point:
  - Take the nearest later stage whose wr equals the source register, with source ≠ 0.
  - If that stage's tnew==0, output its code; otherwise output 0.
  - Farther stages are never considered once a nearer match exists.
- Candidate stages per consumer point:
  - D: E, M (+W, see Configuration).
  - E: M, W.
  - M: W.
- Register 0 never stalls and never forwards.

## Timing
- `stall` and all `fwd_*` outputs are purely combinational from the current records and the D inputs, and are valid in the same cycle.
- Records update only on the rising edge of `clk`.
- Reset: all records clear asynchronously to zero. Consequently `stall`=0 and every `fwd_*`=0 immediately, independent of `clk`.
- Reset asserted mid-stall: the stall drops at once, and the first post-reset edge loads the D tuple into E.
- A LOAD feeding an ALU consumer stalls exactly 1 cycle. A LOAD feeding a BRANCH stalls 2 cycles.
- Simultaneous E and M matches: E wins. If E.tnew>0, the select is 0 and `stall` covers the hazard.

## Configuration
- `AT_HAZ_WB_FWD_EN` defined: the D-stage selects may return 3 (W), for a register file without internal write-through.
- `AT_HAZ_WB_FWD_EN` undefined: `fwd_d_rs`/`fwd_d_rt` never return 3, because the register file bypasses W internally. The W record is still kept for the E and M consumers.

## Structure
- Shared package `at_pkg`:
  - Instype constants.
  - FWD_* select constants.
  - Functions `tuse_rs`, `tuse_rt` and `tnew_e` (classes without a use return a sentinel of 3).
- One sub-module, `at_fwd_sel`, instantiated five times. It takes the source register, the candidate wr/tnew list and a candidate-enable mask, and returns the 2-bit select.

## Test plan
- lw $1 in D, then addu $2,$1,$3:
  - cycle 0: stall=1.
  - cycle 1: stall=0.
  - cycle 2: fwd_e_rs=3.
- addu $4 in E, beq $4,$0 in D:
  - stall=1 for one cycle.
  - Next cycle: fwd_d_rs=2, stall=0.
- jal in E, jr $31 in D: stall=0, fwd_d_rs=1. With the macro undefined and jal in W: fwd_d_rs=0.
- lw $5 in E, sw $5 in D:
  - stall=0.
  - Next cycle: fwd_e_rt=0.
  - Following cycle: fwd_m_rt=3.
- addu $0,$1,$2 followed by addu $3,$0,$0: stall=0, all fwd=0.
- Sequence with lw $1 in E and addu consumer stalled; pull rst_n low mid-cycle: stall and all fwd go to 0 without a clock edge; after release, E loads the D tuple.
